// File: rtl/config_frame_loader.sv
// Configuration bitstream parser: waits for a sync word, then decodes header/frame-data
// groups into a column select, a registered frame word and a one-hot per-frame write strobe.
module config_frame_loader #(
    parameter logic [31:0] SYNC_PATTERN   = 32'hFAB0_FAB1,
    parameter int          COLUMNS        = 16,
    parameter int          FRAMES_PER_COL = 20
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic [31:0]               in_data,
    input  logic                      in_strobe,
    input  logic                      in_active,
    output logic [31:0]               frame_data,
    output logic [COLUMNS-1:0]        frame_col_sel,
    output logic [FRAMES_PER_COL-1:0] frame_strobe,
    output logic                      busy,
    output logic                      done,
    output logic                      error
);

    localparam int IDX_W = 9;

    typedef enum logic [1:0] {
        S_SYNC,
        S_HEADER,
        S_DATA,
        S_ERROR
    } state_t;

    state_t state_reg, state_next;

    logic [15:0]      hdr_count;
    logic [7:0]       hdr_col;
    logic [7:0]       hdr_start;
    logic             col_bad;
    logic             frame_bad;

    logic [IDX_W-1:0] index_reg;
    logic [15:0]      remaining_reg;
    logic             pend_valid_reg;
    logic [IDX_W-1:0] pend_idx_reg;
    logic             pend_last_reg;
    logic             strobe_last_reg;

    logic             load_hdr;
    logic             load_data;
    logic             last_word;
    logic             set_err;
    logic             clr_err;
    logic             done_next;

    logic [COLUMNS-1:0]        col_onehot;
    logic [FRAMES_PER_COL-1:0] strobe_onehot;

    assign hdr_count = in_data[31:16];
    assign hdr_col   = in_data[15:8];
    assign hdr_start = in_data[7:0];

    // 17-bit sum so a huge count can never wrap back into range
    assign col_bad   = ({1'b0, hdr_col} >= 9'(COLUMNS));
    assign frame_bad = (({1'b0, hdr_count} + {9'b0, hdr_start}) > 17'(FRAMES_PER_COL));

    generate
        for (genvar gi = 0; gi < COLUMNS; gi++) begin : g_col_dec
            assign col_onehot[gi] = (hdr_col == 8'(gi));
        end
        for (genvar gi = 0; gi < FRAMES_PER_COL; gi++) begin : g_strobe_dec
            assign strobe_onehot[gi] = pend_valid_reg && (pend_idx_reg == IDX_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg <= S_SYNC;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        load_hdr   = 1'b0;
        load_data  = 1'b0;
        last_word  = 1'b0;
        set_err    = 1'b0;
        clr_err    = 1'b0;
        done_next  = 1'b0;
        // A dropped session flag wins over everything, including a coincident strobe
        if (!in_active) begin
            state_next = S_SYNC;
        end else begin
            case (state_reg)
                S_SYNC: begin
                    if (in_strobe && (in_data == SYNC_PATTERN)) begin
                        state_next = S_HEADER;
                        clr_err    = 1'b1;
                    end
                end
                S_HEADER: begin
                    if (in_strobe) begin
                        if (hdr_count == 16'd0) begin
                            done_next  = 1'b1;
                            state_next = S_SYNC;
                        end else if (col_bad || frame_bad) begin
                            set_err    = 1'b1;
                            state_next = S_ERROR;
                        end else begin
                            load_hdr   = 1'b1;
                            state_next = S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (in_strobe) begin
                        load_data = 1'b1;
                        if (remaining_reg == 16'd1) begin
                            last_word  = 1'b1;
                            state_next = S_HEADER;
                        end
                    end
                end
                default: begin
                    state_next = S_ERROR;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            frame_data      <= '0;
            frame_col_sel   <= '0;
            frame_strobe    <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            error           <= 1'b0;
            index_reg       <= '0;
            remaining_reg   <= '0;
            pend_valid_reg  <= 1'b0;
            pend_idx_reg    <= '0;
            pend_last_reg   <= 1'b0;
            strobe_last_reg <= 1'b0;
        end else begin
            busy <= (state_next == S_HEADER) || (state_next == S_DATA);
            done <= done_next;

            if (set_err) begin
                error <= 1'b1;
            end else if (clr_err) begin
                error <= 1'b0;
            end

            if (load_hdr) begin
                index_reg     <= {1'b0, hdr_start};
                remaining_reg <= hdr_count;
            end else if (load_data) begin
                index_reg     <= index_reg + 1'b1;
                remaining_reg <= remaining_reg - 16'd1;
            end

            if (load_data) begin
                frame_data   <= in_data;
                pend_idx_reg <= index_reg;
            end

            // Strobe trails the data by one cycle; the column stays selected through it
            pend_valid_reg  <= load_data;
            pend_last_reg   <= last_word;
            frame_strobe    <= in_active ? strobe_onehot : '0;
            strobe_last_reg <= in_active && pend_last_reg;

            if (!in_active) begin
                frame_col_sel <= '0;
            end else if (load_hdr) begin
                frame_col_sel <= col_onehot;
            end else if (strobe_last_reg) begin
                frame_col_sel <= '0;
            end
        end
    end

endmodule

// File: tb/tb_config_frame_loader.sv
// Bench for config_frame_loader: directed scenarios then random traffic, every word checked
// over the four following cycles against a transaction-level model of the bitstream rules.
module tb_config_frame_loader;

    localparam logic [31:0] SYNC_W = 32'hFAB0_FAB1;
    localparam int NCOL = 16;
    localparam int NFR  = 20;

    localparam int M_SYNC = 0;
    localparam int M_HDR  = 1;
    localparam int M_DATA = 2;
    localparam int M_ERR  = 3;

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic [31:0]       in_data = '0;
    logic              in_strobe = 1'b0;
    logic              in_active = 1'b1;
    logic [31:0]       frame_data;
    logic [NCOL-1:0]   frame_col_sel;
    logic [NFR-1:0]    frame_strobe;
    logic              busy;
    logic              done;
    logic              error;

    int n_cmp = 0;
    int n_bad = 0;

    // model of the bitstream state as seen from outside
    int          m_mode = M_SYNC;
    logic [31:0] m_col_bits = '0;
    int          m_idx = 0;
    int          m_rem = 0;
    logic        m_err = 1'b0;
    logic [31:0] m_fd = '0;

    config_frame_loader #(
        .SYNC_PATTERN  (SYNC_W),
        .COLUMNS       (NCOL),
        .FRAMES_PER_COL(NFR)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .in_data      (in_data),
        .in_strobe    (in_strobe),
        .in_active    (in_active),
        .frame_data   (frame_data),
        .frame_col_sel(frame_col_sel),
        .frame_strobe (frame_strobe),
        .busy         (busy),
        .done         (done),
        .error        (error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [31:0] ec, input logic [31:0] es,
                             input logic eb, input logic ed, input logic ee, input logic [31:0] ef);
        check({tag, " col_sel"}, 32'(frame_col_sel), ec);
        check({tag, " strobe"},  32'(frame_strobe),  es);
        check({tag, " busy"},    32'(busy),          32'(eb));
        check({tag, " done"},    32'(done),          32'(ed));
        check({tag, " error"},   32'(error),         32'(ee));
        check({tag, " data"},    frame_data,         ef);
    endtask

    // Present one word (act=0 means the session flag is low that cycle), check t+1..t+4
    task automatic send_word(input logic [31:0] w, input bit act);
        logic [31:0] ec [1:4];
        logic [31:0] es [1:4];
        logic        ed [1:4];
        int cnt, col, st;
        for (int k = 1; k <= 4; k++) begin
            ec[k] = m_col_bits;
            es[k] = '0;
            ed[k] = 1'b0;
        end
        cnt = int'(w[31:16]);
        col = int'(w[15:8]);
        st  = int'(w[7:0]);
        if (!act) begin
            m_mode = M_SYNC;
            m_col_bits = '0;
            for (int k = 1; k <= 4; k++) ec[k] = '0;
        end else begin
            case (m_mode)
                M_SYNC: if (w == SYNC_W) begin
                    m_mode = M_HDR;
                    m_err = 1'b0;
                end
                M_HDR: begin
                    if (cnt == 0) begin
                        ed[1] = 1'b1;
                        m_mode = M_SYNC;
                    end else if (col >= NCOL || st + cnt > NFR) begin
                        m_err = 1'b1;
                        m_mode = M_ERR;
                    end else begin
                        m_col_bits = 32'(1) << col;
                        for (int k = 1; k <= 4; k++) ec[k] = m_col_bits;
                        m_idx = st;
                        m_rem = cnt;
                        m_mode = M_DATA;
                    end
                end
                M_DATA: begin
                    m_fd = w;
                    es[2] = 32'(1) << m_idx;
                    m_idx++;
                    m_rem--;
                    if (m_rem == 0) begin
                        ec[3] = '0;
                        ec[4] = '0;
                        m_col_bits = '0;
                        m_mode = M_HDR;
                    end
                end
                default: ;
            endcase
        end
        in_data = w;
        in_strobe = 1'b1;
        in_active = act;
        @(posedge clk); #1;
        in_strobe = 1'b0;
        in_active = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            check_all($sformatf("word %h act%0d t+%0d", w, act, k), ec[k], es[k],
                      (m_mode == M_HDR) || (m_mode == M_DATA), ed[k], m_err, m_fd);
            if (k < 4) begin
                @(posedge clk); #1;
            end
        end
        $display("word %h act=%0d col_sel=%h strobe=%h busy=%0d err=%0d",
                 w, act, frame_col_sel, frame_strobe, busy, error);
    endtask

    // Data word whose strobe is still pending when the session flag drops
    task automatic abort_pending(input logic [31:0] w);
        logic [31:0] col_before;
        col_before = m_col_bits;
        m_fd = w;
        m_mode = M_SYNC;
        m_col_bits = '0;
        in_data = w;
        in_strobe = 1'b1;
        @(posedge clk); #1;
        in_strobe = 1'b0;
        in_active = 1'b0;
        check_all("abort_pend t+1", col_before, '0, 1'b1, 1'b0, m_err, w);
        @(posedge clk); #1;
        in_active = 1'b1;
        for (int k = 2; k <= 4; k++) begin
            check_all($sformatf("abort_pend t+%0d", k), '0, '0, 1'b0, 1'b0, m_err, w);
            @(posedge clk); #1;
        end
        $display("abort with pending strobe, data %h", w);
    endtask

    initial begin
        logic [31:0] w;
        int r;

        // async reset: outputs low with no clock edge needed
        #1;
        check_all("reset", '0, '0, 1'b0, 1'b0, 1'b0, '0);
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        @(posedge clk); #1;
        check_all("post reset", '0, '0, 1'b0, 1'b0, 1'b0, '0);

        // sync plus one frame, then a multi-frame group and end marker
        send_word(SYNC_W, 1);
        send_word(32'h0001_0300, 1);
        send_word(32'hDEAD_BEEF, 1);
        send_word(32'h0003_0102, 1);
        send_word(32'hAAAA_0001, 1);
        send_word(32'hBBBB_0002, 1);
        send_word(32'hCCCC_0003, 1);
        send_word(32'h0000_0000, 1);

        // column range error, ignored words, abort, fresh sync clears error
        send_word(SYNC_W, 1);
        send_word(32'h0002_1000, 1);
        send_word(32'h1234_5678, 1);
        send_word(SYNC_W, 1);
        send_word(32'h0000_0000, 0);
        send_word(SYNC_W, 1);

        // frame overflow, then the largest legal start
        send_word(32'h0002_0013, 1);
        send_word(32'h0000_0000, 0);
        send_word(SYNC_W, 1);
        send_word(32'h0001_0013, 1);
        send_word(32'h5555_AAAA, 1);

        // abort after one of three data words; sync required again
        send_word(32'h0003_0500, 1);
        send_word(32'h0101_0101, 1);
        send_word(32'h0202_0202, 0);
        send_word(32'h0001_0000, 1);
        send_word(SYNC_W, 1);
        send_word(32'h0002_0F00, 1);
        abort_pending(32'h0BAD_F00D);

        // strobe coinciding with the flag dropping is discarded
        send_word(SYNC_W, 0);
        send_word(32'h0001_0000, 1);

        // reset while a strobe is pending
        send_word(SYNC_W, 1);
        send_word(32'h0002_0204, 1);
        in_data = 32'h7777_8888;
        in_strobe = 1'b1;
        @(posedge clk); #1;
        in_strobe = 1'b0;
        resetn = 1'b0;
        #1;
        check_all("reset mid data", '0, '0, 1'b0, 1'b0, 1'b0, '0);
        m_mode = M_SYNC; m_col_bits = '0; m_err = 1'b0; m_fd = '0;
        @(posedge clk); #1;
        resetn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check_all($sformatf("after reset %0d", k), '0, '0, 1'b0, 1'b0, 1'b0, '0);
        end
        send_word(SYNC_W, 0);
        send_word(32'h0001_0000, 1);

        // random traffic
        for (int i = 0; i < 300; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 4) begin
                send_word($urandom, 0);
            end else begin
                case (m_mode)
                    M_SYNC: send_word((r < 70) ? SYNC_W : $urandom, 1);
                    M_HDR: begin
                        if (r < 12) w = '0;
                        else w = {16'($urandom_range(1, 4)), 8'($urandom_range(0, 17)),
                                  8'($urandom_range(0, 20))};
                        send_word(w, 1);
                    end
                    M_DATA: send_word($urandom, (r >= 8));
                    default: send_word($urandom, (r >= 50));
                endcase
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
